// File: rtl/ctl_round.sv
// Duck Hunt round sequencer: spawns ducks, tracks ammo/ducks, issues score pulses and fly-away.
// Latency: every output is registered, responding one cycle after the sampled inputs.
// Backpressure: none; pulse inputs are consumed in the cycle they arrive or ignored.
module ctl_round #(
    parameter int AMMO_PER_DUCK      = 3,
    parameter int DUCKS_PER_ROUND    = 10,
    parameter int FLY_TIMEOUT_FRAMES = 300,
    parameter int SHOW_FRAMES        = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_frame,
    input  logic       start_btn,
    input  logic       shot_fired,
    input  logic       hit,
    input  logic       duck_show,
    output logic       duck_spawn,
    output logic       duck_flyaway,
    output logic       score_inc,
    output logic [3:0] ammo,
    output logic [3:0] ducks_left,
    output logic       game_over,
    output logic [2:0] state
);

    localparam int CNT_MAX = (FLY_TIMEOUT_FRAMES > SHOW_FRAMES) ? FLY_TIMEOUT_FRAMES : SHOW_FRAMES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SPAWN  = 3'd1,
        FLY    = 3'd2,
        HIT    = 3'd3,
        ESCAPE = 3'd4,
        NEXT   = 3'd5,
        OVER   = 3'd6
    } state_t;

    state_t          cur_state, nxt_state;
    logic [CW-1:0]   frame_cnt, cnt_nxt, cnt_inc, frame_step;
    logic [3:0]      ammo_nxt, ducks_nxt;
    logic            score_nxt;

    // Frame counter saturates at all-ones rather than wrapping.
    assign cnt_inc    = (frame_cnt == {CW{1'b1}}) ? frame_cnt : frame_cnt + CW'(1);
    assign frame_step = new_frame ? cnt_inc : frame_cnt;
    assign state      = cur_state;

    always_comb begin
        nxt_state = cur_state;
        cnt_nxt   = frame_cnt;
        ammo_nxt  = ammo;
        ducks_nxt = ducks_left;
        score_nxt = 1'b0;
        case (cur_state)
            IDLE: begin
                if (start_btn) begin
                    nxt_state = SPAWN;
                    ducks_nxt = 4'(DUCKS_PER_ROUND);
                end
            end
            SPAWN: begin
                ammo_nxt  = 4'(AMMO_PER_DUCK);
                cnt_nxt   = '0;
                nxt_state = FLY;
            end
            FLY: begin
                cnt_nxt = frame_step;
                // A shot in the timeout cycle is still honoured; a hit beats the timeout.
                if (shot_fired && (ammo != 4'd0)) begin
                    ammo_nxt = ammo - 4'd1;
                    if (hit) begin
                        score_nxt = 1'b1;
                        nxt_state = HIT;
                        cnt_nxt   = '0;
                    end else if (ammo == 4'd1) begin
                        nxt_state = ESCAPE;
                        cnt_nxt   = '0;
                    end
                end
                if ((nxt_state == FLY) && new_frame && (cnt_inc >= CW'(FLY_TIMEOUT_FRAMES))) begin
                    nxt_state = ESCAPE;
                    cnt_nxt   = '0;
                end
            end
            HIT: begin
                if (frame_cnt == CW'(SHOW_FRAMES)) nxt_state = NEXT;
                else                               cnt_nxt   = frame_step;
            end
            ESCAPE: begin
                if (!duck_show || (frame_cnt == CW'(SHOW_FRAMES))) nxt_state = NEXT;
                else                                                cnt_nxt   = frame_step;
            end
            NEXT: begin
                ducks_nxt = ducks_left - 4'd1;
                if (ducks_left == 4'd1) begin
                    nxt_state = OVER;
                    ammo_nxt  = 4'd0;
                end else begin
                    nxt_state = SPAWN;
                end
            end
            OVER: begin
                ammo_nxt  = 4'd0;
                ducks_nxt = 4'd0;
                if (start_btn) begin
                    nxt_state = SPAWN;
                    ducks_nxt = 4'(DUCKS_PER_ROUND);
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_state    <= IDLE;
            frame_cnt    <= '0;
            ammo         <= 4'd0;
            ducks_left   <= 4'd0;
            score_inc    <= 1'b0;
            duck_spawn   <= 1'b0;
            duck_flyaway <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            cur_state    <= nxt_state;
            frame_cnt    <= cnt_nxt;
            ammo         <= ammo_nxt;
            ducks_left   <= ducks_nxt;
            score_inc    <= score_nxt;
            duck_spawn   <= (nxt_state == SPAWN);
            duck_flyaway <= (nxt_state == ESCAPE);
            game_over    <= (nxt_state == OVER);
        end
    end

endmodule
